// File: rtl/monpro_pkg.sv
// Shared constants and word types for the MonPro (CIOS) datapath.
package monpro_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned TOTAL_ADDR = 32;

  typedef logic [DATA_WIDTH-1:0]   word_t;
  typedef logic [2*DATA_WIDTH-1:0] dword_t;

endpackage

// File: rtl/mul_add_cell_if.sv
// Operand/result bundle between the MonPro sequencer (master) and the MAC cell (slave).
interface mul_add_cell_if #(
  parameter int unsigned DATA_WIDTH = monpro_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] y;
  logic [DATA_WIDTH-1:0] z;
  logic [DATA_WIDTH-1:0] last_c;
  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] c;

  modport master (output x, output y, output z, output last_c, input s, input c);
  modport slave  (input x, input y, input z, input last_c, output s, output c);

endinterface

// File: rtl/mul_add_mult.sv
// Unsigned DATA_WIDTH x DATA_WIDTH multiplier: shifted partial-product array
// reduced by a balanced binary adder tree.
module mul_add_mult #(
  parameter int unsigned DATA_WIDTH = monpro_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   x,
  input  logic [DATA_WIDTH-1:0]   y,
  output logic [2*DATA_WIDTH-1:0] p
);

  localparam int unsigned PW     = 2 * DATA_WIDTH;
  localparam int unsigned LEVELS = $clog2(DATA_WIDTH);
  localparam int unsigned LEAVES = 2 ** LEVELS;

  logic [PW-1:0] pp [LEAVES];

  // Leaves are the gated shifted multiplicands; each level pairs neighbours in place.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      pp[i] = '0;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pp[i] = y[i] ? (PW'(x) << i) : '0;
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < (LEAVES >> (l + 1)); i++) begin
        pp[i] = pp[2*i] + pp[2*i+1];
      end
    end
    p = pp[0];
  end

endmodule

// File: rtl/mul_add_cell.sv
// Word MAC cell {c, s} = x*y + z + last_c, registered output.
// Define MUL_ADD_INPUT_REG_EN to add an operand register stage (latency 2).
module mul_add_cell #(
  parameter int unsigned DATA_WIDTH = monpro_pkg::DATA_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mul_add_cell_if.slave  bus
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [DW-1:0] x_q;
  logic [DW-1:0] y_q;
  logic [DW-1:0] z_q;
  logic [DW-1:0] lc_q;
  logic [PW-1:0] prod;
  logic [PW-1:0] result;
  logic [DW-1:0] s_q;
  logic [DW-1:0] c_q;

`ifdef MUL_ADD_INPUT_REG_EN
  // Operand stage, cleared with the output stage so nothing stale survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      lc_q <= '0;
    end else begin
      x_q  <= bus.x;
      y_q  <= bus.y;
      z_q  <= bus.z;
      lc_q <= bus.last_c;
    end
  end
`else
  assign x_q  = bus.x;
  assign y_q  = bus.y;
  assign z_q  = bus.z;
  assign lc_q = bus.last_c;
`endif

  mul_add_mult #(.DATA_WIDTH(DW)) u_mult (
    .x (x_q),
    .y (y_q),
    .p (prod)
  );

  // Worst case (2^w-1)^2 + 2(2^w-1) = 2^(2w)-1, so the double word never overflows.
  assign result = prod + PW'(z_q) + PW'(lc_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= result[DW-1:0];
      c_q <= result[PW-1:DW];
    end
  end

  assign bus.s = s_q;
  assign bus.c = c_q;

endmodule

// File: tb/tb_mul_add_cell.sv
// Self-checking bench for mul_add_cell (either latency build).
module tb_mul_add_cell;
  import monpro_pkg::*;

`ifdef MUL_ADD_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_add_cell_if bus ();

  mul_add_cell dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    word_t x;
    word_t y;
    word_t z;
    word_t lc;
    word_t s;
    word_t c;
  } vec_t;

  typedef struct {
    word_t s;
    word_t c;
  } exp_t;

  function automatic dword_t ref_mac(word_t a, word_t b, word_t d, word_t e);
    return dword_t'(a) * dword_t'(b) + dword_t'(d) + dword_t'(e);
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input word_t a, input word_t b, input word_t d, input word_t e);
    bus.x      = a;
    bus.y      = b;
    bus.z      = d;
    bus.last_c = e;
  endtask

  // Drive at a negedge, let LAT rising edges pass, read on the following negedge.
  task automatic run_one(input word_t a, input word_t b, input word_t d, input word_t e,
                         output word_t so, output word_t co);
    drive(a, b, d, e);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    so = bus.s;
    co = bus.c;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t   tbl [7];
    exp_t   expq [$];
    exp_t   e;
    word_t  so, co;
    dword_t r;
    word_t  a_w [4];
    word_t  v_w [4];
    word_t  b_w;
    word_t  carry;
    logic [159:0] got160, exp160;

    checks   = 0;
    failures = 0;

    tbl[0] = '{"basic",       32'd2,          32'd3,          32'd4,          32'd5,          32'h0000000F, 32'h00000000};
    tbl[1] = '{"max",         32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[2] = '{"mul_carry",   32'h80000000,   32'd2,          32'd0,          32'd0,          32'h00000000, 32'h00000001};
    tbl[3] = '{"add_carry",   32'd0,          32'd0,          32'hFFFFFFFF,   32'd1,          32'h00000000, 32'h00000001};
    tbl[4] = '{"zero_x_add",  32'd0,          32'h12345678,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    tbl[5] = '{"ident",       32'hFFFFFFFF,   32'd1,          32'd0,          32'd0,          32'hFFFFFFFF, 32'h00000000};
    tbl[6] = '{"pow2",        32'h00010000,   32'h00010000,   32'd0,          32'd0,          32'h00000000, 32'h00000001};

    // Reset state before any clock edge
    reset = 1'b1;
    drive(32'h1, 32'h1, 32'h1, 32'h1);
    #3;
    check("reset_s", 160'(bus.s), 160'(0));
    check("reset_c", 160'(bus.c), 160'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_one(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].lc, so, co);
      check({tbl[i].name, "_s"}, 160'(so), 160'(tbl[i].s));
      check({tbl[i].name, "_c"}, 160'(co), 160'(tbl[i].c));
    end

    // Back-to-back random stream, no bubbles
    for (int cyc = 0; cyc < 40 + LAT; cyc++) begin
      if (cyc >= LAT) begin
        e = expq.pop_front();
        check("stream_s", 160'(bus.s), 160'(e.s));
        check("stream_c", 160'(bus.c), 160'(e.c));
      end
      if (cyc < 40) begin
        word_t a, b, d, f;
        a = $urandom; b = $urandom; d = $urandom; f = $urandom;
        if (cyc % 10 == 3) a = '1;
        if (cyc % 10 == 7) b = '0;
        r = ref_mac(a, b, d, f);
        expq.push_back('{r[31:0], r[63:32]});
        drive(a, b, d, f);
      end
      @(negedge clk);
    end

    // Async reset between edges while outputs are nonzero
    run_one(32'hDEADBEEF, 32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0, so, co);
    r = ref_mac(32'hDEADBEEF, 32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0);
    check("pre_rst_s", 160'(so), 160'(r[31:0]));
    check("pre_rst_c", 160'(co), 160'(r[63:32]));
    #2 reset = 1'b1;
    #1;
    check("async_rst_s", 160'(bus.s), 160'(0));
    check("async_rst_c", 160'(bus.c), 160'(0));
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_s", 160'(bus.s), 160'(0));
    check("rst_hold_c", 160'(bus.c), 160'(0));
    drive(32'h0000FFFF, 32'h00010001, 32'h11111111, 32'h22222222);
    reset = 1'b0;
    #1;
    check("rst_rel_s", 160'(bus.s), 160'(0));
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    r = ref_mac(32'h0000FFFF, 32'h00010001, 32'h11111111, 32'h22222222);
    check("post_rst_s", 160'(bus.s), 160'(r[31:0]));
    check("post_rst_c", 160'(bus.c), 160'(r[63:32]));

    // Carry chain: 4-word A times 1-word b plus 4-word V
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 4; j++) begin
        a_w[j] = (t == 0) ? 32'hFFFFFFFF : word_t'($urandom);
        v_w[j] = (t == 0) ? 32'hFFFFFFFF : word_t'($urandom);
      end
      b_w   = (t == 0) ? 32'hFFFFFFFF : word_t'($urandom);
      carry = '0;
      got160 = '0;
      for (int j = 0; j < 4; j++) begin
        run_one(a_w[j], b_w, v_w[j], carry, so, co);
        got160[32*j +: 32] = so;
        carry = co;
      end
      got160[159:128] = carry;
      exp160 = 160'({a_w[3], a_w[2], a_w[1], a_w[0]}) * 160'(b_w)
             + 160'({v_w[3], v_w[2], v_w[1], v_w[0]});
      check("chain160", got160, exp160);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
